match_sequencer: RTL and testbench

Central game-flow controller for the arcade tennis design. It sequences each match through idle, serve countdown, rally and game-over phases, and keeps both player scores. It consumes the 1 ms tick and the per-point pulses from the ball engine. It drives game_state, scores, serve direction and the ball-release/freeze controls consumed by ball, paddle, render and seven_seg.

---
 rtl/pong_pkg.sv | 17 +
 rtl/rise_detect.sv | 18 +
 rtl/match_sequencer.sv | 148 ++++++++++++++
 tb/tb_match_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared encodings for the tennis game-flow logic: game states, score width
// and serve direction constants.
package pong_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SERVE = 2'b01,
        PLAY  = 2'b10,
        OVER  = 2'b11
    } game_state_t;

    localparam int SCORE_W = 4;

    localparam logic DIR_P1 = 1'b0;
    localparam logic DIR_P2 = 1'b1;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for an already-synchronised level input.
module rise_detect (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (!reset) level_q <= 1'b0;
        else        level_q <= level;
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/match_sequencer.sv
// Match flow controller: IDLE -> SERVE countdown -> PLAY -> OVER, with scoring.
// Define MATCH_SEQUENCER_PAUSE_EN to build the pause toggle for SERVE/PLAY.
module match_sequencer
    import pong_pkg::*;
#(
    parameter int WIN_SCORE = 7,
    parameter int SERVE_MS  = 1500,
    parameter int CNT_W     = 11
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clk_1ms,
    input  logic               start,
    input  logic               point_p1,
    input  logic               point_p2,
    input  logic               pause,
    output logic [1:0]         game_state,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic               serve_dir,
    output logic               ball_release,
    output logic               freeze
);

    localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_MS);
    localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

    game_state_t        state;
    logic [CNT_W-1:0]   countdown;
    logic               start_rise;
    logic               run;       // 0 while paused: ticks and points are dropped
    logic               paused_d;  // paused flag as it will be next cycle

    rise_detect u_start_rise (
        .clk   (clk),
        .reset (reset),
        .level (start),
        .rise  (start_rise)
    );

`ifdef MATCH_SEQUENCER_PAUSE_EN
    logic pause_rise;
    logic paused;

    rise_detect u_pause_rise (
        .clk   (clk),
        .reset (reset),
        .level (pause),
        .rise  (pause_rise)
    );

    assign run = ~paused;

    always_comb begin
        paused_d = 1'b0;
        if (state == SERVE || state == PLAY) paused_d = paused ^ pause_rise;
    end

    always_ff @(posedge clk) begin
        if (!reset) paused <= 1'b0;
        else        paused <= paused_d;
    end
`else
    logic unused_pause;
    assign unused_pause = pause;
    assign run          = 1'b1;
    assign paused_d     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            p1_score     <= '0;
            p2_score     <= '0;
            serve_dir    <= DIR_P1;
            ball_release <= 1'b0;
            freeze       <= 1'b1;
            countdown    <= '0;
        end else begin
            ball_release <= 1'b0;
            case (state)
                IDLE: begin
                    freeze <= 1'b1;
                    if (start_rise) begin
                        p1_score  <= '0;
                        p2_score  <= '0;
                        countdown <= SERVE_LOAD;
                        state     <= SERVE;
                    end
                end
                SERVE: begin
                    freeze <= 1'b1;
                    if (run && clk_1ms) begin
                        countdown <= countdown - 1'b1;
                        if (countdown == CNT_W'(1)) begin
                            state        <= PLAY;
                            ball_release <= 1'b1;
                            freeze       <= paused_d;
                        end
                    end
                end
                PLAY: begin
                    freeze <= paused_d;
                    // simultaneous pulses are a let: replay the serve untouched
                    if (run && point_p1 && point_p2) begin
                        state     <= SERVE;
                        countdown <= SERVE_LOAD;
                        freeze    <= 1'b1;
                    end else if (run && point_p1) begin
                        p1_score  <= p1_score + 1'b1;
                        serve_dir <= DIR_P2;
                        freeze    <= 1'b1;
                        if (p1_score + 1'b1 == WIN) begin
                            state <= OVER;
                        end else begin
                            state     <= SERVE;
                            countdown <= SERVE_LOAD;
                        end
                    end else if (run && point_p2) begin
                        p2_score  <= p2_score + 1'b1;
                        serve_dir <= DIR_P1;
                        freeze    <= 1'b1;
                        if (p2_score + 1'b1 == WIN) begin
                            state <= OVER;
                        end else begin
                            state     <= SERVE;
                            countdown <= SERVE_LOAD;
                        end
                    end
                end
                OVER: begin
                    freeze <= 1'b1;
                    if (start_rise) begin
                        p1_score  <= '0;
                        p2_score  <= '0;
                        serve_dir <= DIR_P1;
                        countdown <= SERVE_LOAD;
                        state     <= SERVE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign game_state = state;

endmodule

// File: tb/tb_match_sequencer.sv
// Scoreboard bench for match_sequencer: stimulus queues expected output snapshots
// with the cycle they must appear; a monitor checks every output change.
module tb_match_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clk_1ms = 1'b0;
    logic       start = 1'b0;
    logic       point_p1 = 1'b0;
    logic       point_p2 = 1'b0;
    logic       pause = 1'b0;
    logic [1:0] game_state;
    logic [3:0] p1_score;
    logic [3:0] p2_score;
    logic       serve_dir;
    logic       ball_release;
    logic       freeze;

    match_sequencer #(.WIN_SCORE(3), .SERVE_MS(3), .CNT_W(11)) dut (
        .clk          (clk),
        .reset        (reset),
        .clk_1ms      (clk_1ms),
        .start        (start),
        .point_p1     (point_p1),
        .point_p2     (point_p2),
        .pause        (pause),
        .game_state   (game_state),
        .p1_score     (p1_score),
        .p2_score     (p2_score),
        .serve_dir    (serve_dir),
        .ball_release (ball_release),
        .freeze       (freeze)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] st;
        logic [3:0] p1;
        logic [3:0] p2;
        logic       dir;
        logic       rel;
        logic       frz;
    } snap_t;

    snap_t exp_q[$];
    int    cyc_q[$];
    int    cyc = 0;
    int    checks = 0;
    int    passed = 0;
    snap_t e;

    always @(posedge clk) cyc <= cyc + 1;

    // monitor: any change of the output snapshot must match the next expectation
    snap_t prev = 'x;
    snap_t now;
    snap_t es;
    int    ec;
    always @(negedge clk) begin
        now = {game_state, p1_score, p2_score, serve_dir, ball_release, freeze};
        if (now !== prev) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_change cyc=%0d got=%h expected no change", cyc, now);
            end else begin
                es = exp_q.pop_front();
                ec = cyc_q.pop_front();
                checks += 2;
                if (now === es) passed++;
                else $display("FAIL snapshot cyc=%0d got st=%b p1=%0d p2=%0d dir=%b rel=%b frz=%b need st=%b p1=%0d p2=%0d dir=%b rel=%b frz=%b",
                              cyc, now.st, now.p1, now.p2, now.dir, now.rel, now.frz,
                              es.st, es.p1, es.p2, es.dir, es.rel, es.frz);
                if (cyc == ec) passed++;
                else $display("FAIL timing got cyc=%0d need cyc=%0d (snapshot %h)", cyc, ec, es);
            end
            prev = now;
        end
    end

    task automatic push();
        exp_q.push_back(e);
        cyc_q.push_back(cyc + 1);
    endtask

    task automatic reset_snap();
        e.st = 2'b00; e.p1 = 4'd0; e.p2 = 4'd0; e.dir = 1'b0; e.rel = 1'b0; e.frz = 1'b1;
    endtask

    task automatic drive(input logic s, input logic t, input logic a, input logic b, input logic pz);
        @(negedge clk);
        start = s; clk_1ms = t; point_p1 = a; point_p2 = b; pause = pz;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // three 1 ms ticks spaced 4 clk apart; PLAY with a one-clk release after the third
    task automatic countdown_to_play();
        for (int k = 0; k < 3; k++) begin
            idle(3);
            drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            if (k == 2) begin
                e.st = 2'b10; e.rel = 1'b1; e.frz = 1'b0;
                push();
            end
        end
        idle(1);
        e.rel = 1'b0;
        push();
    endtask

    initial begin
        reset_snap();
        push();
        idle(2);
        reset = 1'b1;
        idle(2);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        e.st = 2'b01;
        push();
        countdown_to_play();
        idle(2);

        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        e.st = 2'b01; e.p2 = 4'd1; e.dir = 1'b0; e.frz = 1'b1;
        push();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        countdown_to_play();
        idle(1);

        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        e.st = 2'b01; e.frz = 1'b1;
        push();
        countdown_to_play();

        for (int k = 1; k <= 3; k++) begin
            idle(1);
            drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            e.p1 = 4'(k); e.dir = 1'b1; e.frz = 1'b1;
            e.st = (k == 3) ? 2'b11 : 2'b01;
            push();
            if (k < 3) countdown_to_play();
        end
        idle(2);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idle(3);

        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        e.st = 2'b01; e.p1 = 4'd0; e.p2 = 4'd0; e.dir = 1'b0;
        push();
        countdown_to_play();
        idle(1);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        e.st = 2'b01; e.p2 = 4'd1; e.frz = 1'b1;
        push();
        idle(3);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        idle(2);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        reset_snap();
        push();
        idle(2);
        reset = 1'b1;
        idle(2);

`ifdef MATCH_SEQUENCER_PAUSE_EN
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        e.st = 2'b01;
        push();
        countdown_to_play();
        idle(1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        e.frz = 1'b1;
        push();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idle(2);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        e.frz = 1'b0;
        push();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        e.st = 2'b01; e.p1 = 4'd1; e.dir = 1'b1; e.frz = 1'b1;
        push();
`endif

        idle(4);
        checks++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL pending_expectations left=%0d need=0", exp_q.size());
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d need finish before time limit", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
